// File: rtl/serial_fa_sequencer.sv
// Bit-serial add controller: arbitrates two requesters round-robin, then
// drives one external full-adder cell LSB first for WIDTH cycles with a
// registered carry, and returns sum and carry-out over a valid/ready port.
module serial_fa_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    input  logic             REQ0_CIN,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    input  logic             REQ1_CIN,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_SUM,
    output logic             RSP_COUT,
    output logic             RSP_ID,
    output logic             BUSY,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_CIN,
    input  logic             FA_SUM,
    input  logic             FA_COUT
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             any_valid;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_final;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             id;

    // Round-robin pick: with both requesters valid, favour the one not served last.
    assign any_valid = REQ0_VALID | REQ1_VALID;
    assign grant     = (REQ0_VALID & REQ1_VALID) ? ~last_grant : REQ1_VALID;
    assign sum_final = {FA_SUM, sum_sh[WIDTH-1:1]};

    // The shifters and carry are zero outside RUN, so the FA pins come straight
    // from flops with no state gating and stay glitch-free and 0 when not running.
    assign FA_A      = a_sh[0];
    assign FA_B      = b_sh[0];
    assign FA_CIN    = carry;
    assign RSP_VALID = (state == DONE);
    assign BUSY      = (state != IDLE);

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: every sequential assignment uses <= so all flops update from
        // pre-edge values regardless of statement order.
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and requester handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves one unassigned, which would infer a latch.
        state_next = state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        case (state)
            IDLE: begin
                REQ0_READY = REQ0_VALID & ~grant;
                REQ1_READY = REQ1_VALID &  grant;
                if (any_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST_BIT) state_next = DONE;
            end
            DONE: begin
                if (RSP_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and result capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            RSP_SUM    <= '0;
            RSP_COUT   <= 1'b0;
            RSP_ID     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_sh       <= grant ? REQ1_A   : REQ0_A;
                        b_sh       <= grant ? REQ1_B   : REQ0_B;
                        carry      <= grant ? REQ1_CIN : REQ0_CIN;
                        cnt        <= '0;
                        id         <= grant;
                        last_grant <= grant;
                    end
                end
                RUN: begin
                    sum_sh <= sum_final;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= FA_COUT;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        RSP_SUM  <= sum_final;
                        RSP_COUT <= FA_COUT;
                        RSP_ID   <= id;
                        // Carry is parked at 0 so FA_CIN is low while DONE.
                        carry    <= 1'b0;
                        cnt      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Directed and randomized bench for serial_fa_sequencer with a behavioural
// full-adder cell attached to the FA pins.
module tb_serial_fa_sequencer;

    localparam int WIDTH    = 8;
    localparam int RSP_WAIT = 4 * WIDTH;
    localparam int N_RAND   = 1000;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             REQ0_VALID, REQ0_READY, REQ0_CIN;
    logic [WIDTH-1:0] REQ0_A, REQ0_B;
    logic             REQ1_VALID, REQ1_READY, REQ1_CIN;
    logic [WIDTH-1:0] REQ1_A, REQ1_B;
    logic             RSP_VALID, RSP_READY, RSP_COUT, RSP_ID, BUSY;
    logic [WIDTH-1:0] RSP_SUM;
    logic             FA_A, FA_B, FA_CIN, FA_SUM, FA_COUT;

    int errors = 0;
    int checks = 0;

    serial_fa_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_CIN(REQ0_CIN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_CIN(REQ1_CIN),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_SUM(RSP_SUM), .RSP_COUT(RSP_COUT), .RSP_ID(RSP_ID),
        .BUSY(BUSY),
        .FA_A(FA_A), .FA_B(FA_B), .FA_CIN(FA_CIN),
        .FA_SUM(FA_SUM), .FA_COUT(FA_COUT)
    );

    // Behavioural full-adder cell.
    assign FA_SUM  = FA_A ^ FA_B ^ FA_CIN;
    assign FA_COUT = (FA_A & FA_B) | (FA_CIN & (FA_A ^ FA_B));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET      = 1'b1;
        REQ0_VALID = 1'b0; REQ0_A = '0; REQ0_B = '0; REQ0_CIN = 1'b0;
        REQ1_VALID = 1'b0; REQ1_A = '0; REQ1_B = '0; REQ1_CIN = 1'b0;
        RSP_READY  = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    function automatic logic [WIDTH+8:0] out_vec();
        return {REQ0_READY, REQ1_READY, RSP_VALID, RSP_COUT, RSP_ID,
                BUSY, FA_A, FA_B, FA_CIN, RSP_SUM};
    endfunction

    task automatic wait_rsp(output bit ok);
        for (int i = 0; i < RSP_WAIT && !RSP_VALID; i++) tick();
        ok = RSP_VALID;
    endtask

    // One single-requester operation with RSP_READY=1, checking the FA pin
    // sequence, the response latency and the response fields.
    task automatic run_op(input string tag, input bit who,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit cin,
                          input logic [WIDTH-1:0] exp_sum, input bit exp_cout);
        logic [WIDTH-1:0] sa, sb, sc, ec;
        logic c;
        bit   quiet;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            ec[i] = c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        RSP_READY = 1'b1;
        if (who) begin
            REQ1_A = a; REQ1_B = b; REQ1_CIN = cin; REQ1_VALID = 1'b1;
        end else begin
            REQ0_A = a; REQ0_B = b; REQ0_CIN = cin; REQ0_VALID = 1'b1;
        end
        #1;
        check({tag, "_ready"}, who ? REQ1_READY : REQ0_READY, 1);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            sa[i] = FA_A;
            sb[i] = FA_B;
            sc[i] = FA_CIN;
            if (RSP_VALID) quiet = 1'b0;
            tick();
        end
        check({tag, "_fa_a_seq"}, sa, a);
        check({tag, "_fa_b_seq"}, sb, b);
        check({tag, "_fa_cin_seq"}, sc, ec);
        check({tag, "_no_early_rsp"}, quiet, 1);
        check({tag, "_rsp_valid"}, RSP_VALID, 1);
        check({tag, "_rsp"}, {RSP_ID, RSP_COUT, RSP_SUM}, {who, exp_cout, exp_sum});
        tick();
        check({tag, "_idle_after"}, {RSP_VALID, BUSY}, 2'b00);
    endtask

    initial begin
        bit ok;
        bit seen;
        logic [WIDTH+1:0] exp_q[$];
        logic [WIDTH+1:0] exp_v;
        logic [WIDTH:0]   s;
        bit               pv[2];
        int               accepted, done_cnt, excl_err, cyc;

        // Reset state
        apply_reset();
        check("reset_outputs", out_vec(), 0);

        // Basic add and carry boundaries
        run_op("basic",    1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        run_op("wrap",     1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("all_ones", 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("cin_only", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Contention from reset: grants alternate 0,1,0,1
        apply_reset();
        RSP_READY = 1'b1;
        REQ0_A = 8'h10; REQ0_B = 8'h20; REQ0_CIN = 1'b0;
        REQ1_A = 8'hC0; REQ1_B = 8'h50; REQ1_CIN = 1'b1;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("cont_excl", REQ0_READY & REQ1_READY, 0);
            check("cont_grant", {REQ0_READY, REQ1_READY}, (k % 2) ? 2'b01 : 2'b10);
            tick();
            wait_rsp(ok);
            check("cont_rsp_timeout", ok, 1);
            check("cont_rsp", {RSP_ID, RSP_COUT, RSP_SUM},
                  (k % 2) ? {1'b1, 1'b1, 8'h11} : {1'b0, 1'b0, 8'h30});
            tick();
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        tick();

        // Backpressure in DONE with another request pending
        RSP_READY  = 1'b0;
        REQ0_A = 8'h7F; REQ0_B = 8'h01; REQ0_CIN = 1'b0; REQ0_VALID = 1'b1;
        tick();
        REQ0_VALID = 1'b0;
        REQ1_A = 8'h03; REQ1_B = 8'h04; REQ1_CIN = 1'b0; REQ1_VALID = 1'b1;
        wait_rsp(ok);
        check("bp_rsp_timeout", ok, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_rsp", {RSP_VALID, RSP_ID, RSP_COUT, RSP_SUM}, {1'b1, 1'b0, 1'b0, 8'h80});
            check("bp_hold_ctl", {REQ0_READY, REQ1_READY, BUSY}, 3'b001);
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        check("bp_release", {RSP_VALID, BUSY, REQ1_READY}, 3'b001);
        tick();
        REQ1_VALID = 1'b0;
        wait_rsp(ok);
        check("bp_next_rsp", {ok, RSP_ID, RSP_COUT, RSP_SUM}, {1'b1, 1'b1, 1'b0, 8'h07});
        tick();

        // Reset in the middle of RUN
        REQ0_A = 8'hAA; REQ0_B = 8'h55; REQ0_CIN = 1'b1; REQ0_VALID = 1'b1;
        tick();
        REQ0_VALID = 1'b0;
        tick(); tick(); tick();
        RESET = 1'b1;
        tick();
        check("midreset_outputs", out_vec(), 0);
        RESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            seen |= RSP_VALID;
            tick();
        end
        check("midreset_no_rsp", seen, 0);
        REQ0_A = 8'h01; REQ0_B = 8'h02; REQ0_CIN = 1'b0; REQ0_VALID = 1'b1;
        REQ1_A = 8'h04; REQ1_B = 8'h08; REQ1_CIN = 1'b0; REQ1_VALID = 1'b1;
        #1;
        check("midreset_first_grant", {REQ0_READY, REQ1_READY}, 2'b10);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        wait_rsp(ok);
        check("midreset_rsp", {ok, RSP_ID, RSP_COUT, RSP_SUM}, {1'b1, 1'b0, 1'b0, 8'h03});
        tick();

        // Random traffic against an arithmetic reference model
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        accepted = 0;
        done_cnt = 0;
        excl_err = 0;
        cyc      = 0;
        while (done_cnt < N_RAND && cyc < 60000) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && (accepted + int'(pv[0]) + int'(pv[1])) < N_RAND
                    && $urandom_range(0, 1) == 1) begin
                    pv[r] = 1'b1;
                    if (r == 0) begin
                        REQ0_A = WIDTH'($urandom); REQ0_B = WIDTH'($urandom);
                        REQ0_CIN = 1'($urandom);
                    end else begin
                        REQ1_A = WIDTH'($urandom); REQ1_B = WIDTH'($urandom);
                        REQ1_CIN = 1'($urandom);
                    end
                end else if (pv[r] && $urandom_range(0, 9) == 0) begin
                    pv[r] = 1'b0;
                end
            end
            REQ0_VALID = pv[0];
            REQ1_VALID = pv[1];
            RSP_READY  = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            if (REQ0_READY && REQ1_READY) excl_err++;
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_rsp", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rnd_rsp", {RSP_ID, RSP_COUT, RSP_SUM}, exp_v);
                end
                done_cnt++;
            end
            if (pv[0] && REQ0_READY) begin
                s = {1'b0, REQ0_A} + {1'b0, REQ0_B} + {{WIDTH{1'b0}}, REQ0_CIN};
                exp_q.push_back({1'b0, s});
                pv[0] = 1'b0;
                accepted++;
            end
            if (pv[1] && REQ1_READY) begin
                s = {1'b0, REQ1_A} + {1'b0, REQ1_B} + {{WIDTH{1'b0}}, REQ1_CIN};
                exp_q.push_back({1'b1, s});
                pv[1] = 1'b0;
                accepted++;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("rnd_done_count", done_cnt, N_RAND);
        check("rnd_accepted", accepted, N_RAND);
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_ready_exclusive", excl_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
